// File: rtl/floo_pkg.sv
// Shared FlooNoC types for the destination-ID stage: coordinate ids, the
// routed destination bundle and the output-buffer occupancy encoding.
package floo_pkg;

  // Widest coordinate any stage in this NoC may use; stages keep the low bits.
  localparam int unsigned MaxIdWidth = 8;

  typedef logic [MaxIdWidth-1:0] x_id_t;
  typedef logic [MaxIdWidth-1:0] y_id_t;

  typedef struct packed {
    x_id_t x;
    y_id_t y;
    logic  err;
  } dst_id_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/floo_mask_extract.sv
// Gathers the address bits selected by Mask into a dense field, lowest
// selected bit first.
module floo_mask_extract #(
  parameter int unsigned           AddrWidth = 32,
  parameter logic [AddrWidth-1:0]  Mask      = '0,
  parameter int unsigned           OutWidth  = 1
) (
  input  logic [AddrWidth-1:0] addr,
  output logic [OutWidth-1:0]  id
);

  int unsigned idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    id  = '0;
    idx = 0;
    for (int unsigned i = 0; i < AddrWidth; i++) begin
      if (Mask[i]) begin
        id[idx] = addr[i];
        idx     = idx + 1;
      end
    end
  end

endmodule

// File: rtl/floo_dst_id_stage.sv
// Destination-ID stage: extracts and range-checks X/Y coordinates from the
// request address and forwards them through a 2-entry registered-ready buffer.
module floo_dst_id_stage
  import floo_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter type                  payload_t = logic,
  parameter logic [AddrWidth-1:0] XIdMask   = '0,
  parameter logic [AddrWidth-1:0] YIdMask   = '0,
  parameter int unsigned          XIdWidth  = 1,
  parameter int unsigned          YIdWidth  = 1,
  parameter int unsigned          NumX      = 1,
  parameter int unsigned          NumY      = 1,
  parameter int unsigned          CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  payload_t             payload_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output payload_t             payload_o,
  output logic [XIdWidth-1:0]  dst_x_o,
  output logic [YIdWidth-1:0]  dst_y_o,
  output logic                 dst_err_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  input  logic                 clr_err_i
);

  if ($countones(XIdMask) != XIdWidth) begin : gen_x_width_check
    $error("XIdWidth must equal the number of bits set in XIdMask");
  end
  if ($countones(YIdMask) != YIdWidth) begin : gen_y_width_check
    $error("YIdWidth must equal the number of bits set in YIdMask");
  end
  if ((XIdMask & YIdMask) != '0) begin : gen_overlap_check
    $error("XIdMask and YIdMask must not overlap");
  end
  if (XIdWidth > MaxIdWidth || YIdWidth > MaxIdWidth) begin : gen_max_width_check
    $error("coordinate width exceeds floo_pkg::MaxIdWidth");
  end
  if (NumX > 2 ** XIdWidth || NumY > 2 ** YIdWidth) begin : gen_range_check
    $error("NumX/NumY not representable in XIdWidth/YIdWidth");
  end

  typedef struct packed {
    payload_t payload;
    dst_id_t  dst;
  } entry_t;

  logic [XIdWidth-1:0] x_raw;
  logic [YIdWidth-1:0] y_raw;
  logic                in_err;
  dst_id_t             in_dst;

  floo_mask_extract #(
    .AddrWidth (AddrWidth),
    .Mask      (XIdMask),
    .OutWidth  (XIdWidth)
  ) i_x_extract (
    .addr (addr_i),
    .id   (x_raw)
  );

  floo_mask_extract #(
    .AddrWidth (AddrWidth),
    .Mask      (YIdMask),
    .OutWidth  (YIdWidth)
  ) i_y_extract (
    .addr (addr_i),
    .id   (y_raw)
  );

  assign in_err     = (32'(x_raw) >= NumX) | (32'(y_raw) >= NumY);
  // Out-of-range requests still travel downstream, with zeroed coordinates.
  assign in_dst.x   = in_err ? '0 : x_id_t'(x_raw);
  assign in_dst.y   = in_err ? '0 : y_id_t'(y_raw);
  assign in_dst.err = in_err;

  occ_e   occ_q, occ_d;
  logic   ready_q;
  logic   wr_ptr_q, rd_ptr_q;
  entry_t mem_q [2];
  entry_t head;
  logic   in_fire, out_fire, err_fire;

  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_o & ready_i;
  assign err_fire = in_fire & in_err;

  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: if (in_fire) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (in_fire && !out_fire)      occ_d = OCC_FULL;
        else if (!in_fire && out_fire) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (out_fire) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q    <= OCC_EMPTY;
      ready_q  <= 1'b1;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d != OCC_FULL);
      if (in_fire)  wr_ptr_q <= ~wr_ptr_q;
      if (out_fire) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (in_fire) mem_q[wr_ptr_q] <= '{payload: payload_i, dst: in_dst};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (clr_err_i) begin
      // A clear coinciding with an erroneous request still records that request.
      err_cnt_o <= err_fire ? CntWidth'(1) : '0;
    end else if (err_fire && err_cnt_o != '1) begin
      err_cnt_o <= err_cnt_o + CntWidth'(1);
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign valid_o   = (occ_q != OCC_EMPTY);
  assign ready_o   = ready_q;
  assign payload_o = head.payload;
  assign dst_x_o   = head.dst.x[XIdWidth-1:0];
  assign dst_y_o   = head.dst.y[YIdWidth-1:0];
  assign dst_err_o = head.dst.err;

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(payload_o) && $stable(dst_x_o) &&
                               $stable(dst_y_o) && $stable(dst_err_o)))
    else $error("output changed while stalled");

  a_in_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> valid_i)
    else $error("valid_i dropped before acceptance");

endmodule

// File: tb/tb_floo_dst_id_stage.sv
// Self-checking bench for floo_dst_id_stage: a queue-based reference model
// tracks buffered requests and the saturating error counters of two instances.
module tb_floo_dst_id_stage;

  localparam int unsigned AddrWidth = 32;
  typedef logic [15:0] pl_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_i = 1'b0;
  logic                 ready_i = 1'b0;
  logic                 clr_err = 1'b0;
  logic [AddrWidth-1:0] addr_i = '0;
  pl_t                  payload_i = '0;

  logic        ready0, valid0, err0;
  pl_t         payload0;
  logic [1:0]  x0, y0;
  logic [15:0] cnt0;
  logic        ready1, valid1, err1;
  pl_t         payload1;
  logic [1:0]  x1, y1;
  logic [1:0]  cnt1;

  floo_dst_id_stage #(
    .AddrWidth (AddrWidth), .payload_t (pl_t),
    .XIdMask   (32'h3000),  .YIdMask   (32'hC000),
    .XIdWidth  (2), .YIdWidth (2), .NumX (3), .NumY (4), .CntWidth (16)
  ) dut (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (ready0),
    .addr_i (addr_i), .payload_i (payload_i), .valid_o (valid0), .ready_i (ready_i),
    .payload_o (payload0), .dst_x_o (x0), .dst_y_o (y0), .dst_err_o (err0),
    .err_cnt_o (cnt0), .clr_err_i (clr_err)
  );

  floo_dst_id_stage #(
    .AddrWidth (AddrWidth), .payload_t (pl_t),
    .XIdMask   (32'h3000),  .YIdMask   (32'hC000),
    .XIdWidth  (2), .YIdWidth (2), .NumX (3), .NumY (4), .CntWidth (2)
  ) dut_sat (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (ready1),
    .addr_i (addr_i), .payload_i (payload_i), .valid_o (valid1), .ready_i (ready_i),
    .payload_o (payload1), .dst_x_o (x1), .dst_y_o (y1), .dst_err_o (err1),
    .err_cnt_o (cnt1), .clr_err_i (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    pl_t        payload;
    logic [1:0] x;
    logic [1:0] y;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;
  int   out_count = 0;
  bit   last_in_fire = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: coordinates are address fields [13:12] and [15:14].
  function automatic exp_t model_entry(input logic [31:0] a, input pl_t p);
    exp_t e;
    int   x, y;
    x = (a / 32'h1000) % 4;
    y = (a / 32'h4000) % 4;
    e.payload = p;
    e.err     = (x >= 3) || (y >= 4);
    e.x       = e.err ? 2'd0 : 2'(x);
    e.y       = e.err ? 2'd0 : 2'(y);
    return e;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endfunction

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit   in_f, out_f, err_f;
    exp_t e;
    @(negedge clk);
    check("valid_o", 32'(valid0), 32'(q.size() != 0));
    check("ready_o", 32'(ready0), 32'(q.size() < 2));
    check("sat_valid_o", 32'(valid1), 32'(q.size() != 0));
    check("err_cnt", 32'(cnt0), m_cnt0);
    check("sat_err_cnt", 32'(cnt1), m_cnt1);
    if (q.size() != 0) begin
      check("payload_o", 32'(payload0), 32'(q[0].payload));
      check("dst_x_o", 32'(x0), 32'(q[0].x));
      check("dst_y_o", 32'(y0), 32'(q[0].y));
      check("dst_err_o", 32'(err0), 32'(q[0].err));
    end
    in_f  = valid_i && (q.size() < 2);
    out_f = (q.size() != 0) && ready_i;
    e     = model_entry(addr_i, payload_i);
    err_f = in_f && e.err;
    @(posedge clk);
    if (out_f) begin
      void'(q.pop_front());
      out_count++;
    end
    if (in_f) q.push_back(e);
    if (clr_err) begin
      m_cnt0 = err_f ? 1 : 0;
      m_cnt1 = err_f ? 1 : 0;
    end else if (err_f) begin
      if (m_cnt0 < 65535) m_cnt0++;
      if (m_cnt1 < 3)     m_cnt1++;
    end
    last_in_fire = in_f;
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input pl_t p);
    valid_i   = v;
    addr_i    = a;
    payload_i = p;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[13:12] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    // Reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(valid0), 0);
    check("rst_ready_o", 32'(ready0), 1);
    check("rst_err_cnt", 32'(cnt0), 0);
    rst = 1'b0;
    tick();

    // Single in-range request
    ready_i = 1'b1;
    drive(1, 32'h6000, 16'hA001);
    tick();
    drive(0, '0, '0);
    check("single_valid", 32'(valid0), 1);
    check("single_x", 32'(x0), 2);
    check("single_y", 32'(y0), 1);
    check("single_err", 32'(err0), 0);
    tick();

    // Out-of-range X
    drive(1, 32'h3000, 16'hBEEF);
    tick();
    drive(0, '0, '0);
    check("err_flag", 32'(err0), 1);
    check("err_x_zero", 32'(x0), 0);
    check("err_payload", 32'(payload0), 32'hBEEF);
    check("err_cnt_one", 32'(cnt0), 1);
    tick();

    // Three back-to-back requests into a stalled output
    ready_i = 1'b0;
    drive(1, 32'h0000, 16'h000A);
    tick();
    drive(1, 32'h5000, 16'h000B);
    tick();
    check("stall_ready_low", 32'(ready0), 0);
    drive(1, 32'h2000, 16'h000C);
    tick();
    check("stall_c_held", 32'(last_in_fire), 0);
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (last_in_fire) drive(0, '0, '0);
      tick();
    end
    check("stall_drained", 32'(q.size()), 0);

    // Streaming: one output per cycle after one cycle of latency
    out_count = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, rand_addr(), pl_t'($urandom()));
      tick();
      check("stream_accept", 32'(last_in_fire), 1);
    end
    drive(0, '0, '0);
    tick();
    check("stream_out_count", out_count, 100);

    // Clear coinciding with an erroneous fire
    drive(1, 32'h3000, 16'h0C1E);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    drive(0, '0, '0);
    check("clr_with_err", 32'(cnt0), 1);
    tick();

    // Clear alone, then five errors saturate the 2-bit counter
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_alone", 32'(cnt0), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h7000 | 32'(i), pl_t'(16'h5A00 + i));
      tick();
    end
    drive(0, '0, '0);
    check("sat_cnt_3", 32'(cnt1), 3);
    check("wide_cnt_5", 32'(cnt0), 5);
    tick();

    // Random traffic with random back-pressure and clears
    for (int i = 0; i < 400; i++) begin
      if (!(valid_i && !last_in_fire))
        drive(bit'($urandom_range(0, 1)), rand_addr(), pl_t'($urandom()));
      ready_i = ($urandom_range(0, 3) != 0);
      clr_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    clr_err = 1'b0;
    if (!(valid_i && !last_in_fire)) drive(0, '0, '0);
    ready_i = 1'b1;
    while (valid_i && !last_in_fire) tick();
    drive(0, '0, '0);
    repeat (3) tick();

    // Asynchronous reset with two entries buffered
    ready_i = 1'b0;
    drive(1, 32'h3000, 16'h1111);
    tick();
    drive(1, 32'h3000, 16'h2222);
    tick();
    drive(0, '0, '0);
    check("pre_rst_full", 32'(ready0), 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_o", 32'(valid0), 0);
    check("arst_ready_o", 32'(ready0), 1);
    check("arst_err_cnt", 32'(cnt0), 0);
    model_reset();
    tick();
    rst = 1'b0;
    ready_i = 1'b1;
    drive(1, 32'h6000, 16'h3333);
    tick();
    drive(0, '0, '0);
    check("post_rst_valid", 32'(valid0), 1);
    check("post_rst_payload", 32'(payload0), 32'h3333);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
